ig_xfer_ctrl: RTL and testbench
===============================

Name: ig_xfer_ctrl

Overview:
Ingress transfer controller directly downstream of the 4-port round-robin arbiter. It takes the arbiter's port select (ig_sel) and grant strobe and latches the selected port's burst descriptor. It then muxes that port's data beats onto the internal bus under an int_valid/int_ready handshake. It drives trans_started and int_valid back to the arbiter so the next arbitration round is held off until the bus is idle.

Parameters:
DW, 32, data width in bits; a power of 2, at least 8.
AW, 32, address width in bits.
LENW, 4, burst-length field width; the burst is ig_len+1 beats.
TMO, 256, stall watchdog limit in cycles without an accepted beat; 0 disables the watchdog.

Ports:
clk  in  1  clock
rstN  in  1  reset, asynchronous, active-low
ig_req  in  4  per-port transfer request; must be held until ig_done
ig_sel  in  2  arbiter-selected port
gnt_vld  in  1  one-cycle strobe: ig_sel is a valid grant
ig_addr  in  4*AW  per-port start address; port p occupies [p*AW +: AW]
ig_len  in  4*LENW  per-port beats minus 1
ig_data  in  4*DW  per-port beat data
ig_dvalid  in  4  per-port beat valid
ig_dack  out  4  per-port beat accepted (one-hot or zero)
ig_done  out  4  per-port one-cycle completion pulse
int_valid  out  1  internal bus beat valid
int_ready  in  1  internal bus ready
int_addr  out  AW  beat address
int_data  out  DW  beat data
int_first  out  1  first beat of burst
int_last  out  1  last beat of burst
trans_started  out  1  transfer in progress
xfer_err  out  1  one-cycle pulse: burst aborted by watchdog
gnt_err  out  1  one-cycle pulse: grant ignored

Behaviour:
- Reset (async): state=IDLE. All outputs are 0, and the port, address, count and watchdog registers are 0. Reset mid-burst abandons the burst with no ig_done.
- FSM states: IDLE, START, XFER, DONE.
- IDLE:
  - gnt_vld & ig_req[ig_sel]: latch port=ig_sel, addr=ig_addr[port], len=ig_len[port]; beat_cnt=0, wd=0; go to START.
  - gnt_vld & !ig_req[ig_sel]: gnt_err pulse next cycle; stay in IDLE.
- START: exactly one cycle; trans_started=1; go to XFER.
- XFER:
  - int_valid = ig_dvalid[port] (combinational mux). int_data = ig_data[port]. int_addr = registered addr.
  - int_first = (beat_cnt==0). int_last = (beat_cnt==len).
  - Beat accepted = int_valid & int_ready. On accept: ig_dack[port]=1 in the same cycle; addr += DW/8 (modulo 2^AW, wraps silently); beat_cnt += 1; wd=0.
  - Last beat accepted: go to DONE.
- Watchdog (TMO>0, XFER only):
  - wd increments each cycle with no accept, whether or not int_valid is high.
  - wd==TMO-1 with no accept: go to DONE with abort flag set.
  - Accept and watchdog expiry in the same cycle: the accept wins.
- DONE: one cycle; trans_started=0; int_valid=0.
  - Normal completion: ig_done[port]=1.
  - Abort: xfer_err=1 instead, and ig_done stays 0.
  - Go to IDLE.
- trans_started = state in {START, XFER}, registered from state.
- Latency: gnt_vld to first int_valid opportunity is 2 cycles. Last accept to ig_done is 1 cycle. DONE to the next START is at least 1 IDLE cycle.
- gnt_vld in any state other than IDLE: ignored; gnt_err pulse.
- ig_req dropped mid-burst: ignored; the burst continues until last beat or watchdog.
- ig_len and ig_addr changes after latch: ignored.
- ig_dvalid on non-selected ports: ignored; their ig_dack stays 0.
- len=0: single beat, with int_first and int_last both high.
- beat_cnt is LENW bits; it never wraps because DONE is taken at beat_cnt==len.

Decomposition:
- Shared package ig_pkg holds:
  - state enum: IDLE=2'd0, START=2'd1, XFER=2'd2, DONE=2'd3;
  - NUM_PORTS=4;
  - the port index typedef (2 bits).
- One sub-module, ig_port_mux: a pure 4:1 mux of {addr, len, data, dvalid} indexed by port, instantiated twice. One instance uses ig_sel for the descriptor latch; the other uses the latched port for the beat path.
- The watchdog counter stays inline.

Test Plan:
- Normal burst: port 2, addr=0x100, len=3, int_ready=1, dvalid=1. Expect 4 beats at int_addr 0x100, 0x104, 0x108, 0x10C; int_first on beat 0 and int_last on beat 3; ig_dack=4'b0100 on each beat; ig_done=4'b0100 one cycle after the last beat.
- Backpressure: port 0, len=1, int_ready toggling 0,1,0,1. Expect each beat held stable while ready is low; 2 accepts total; no xfer_err.
- Watchdog abort: TMO=8, port 1, dvalid=0 throughout XFER. Expect xfer_err at DONE after 8 XFER cycles; ig_done=0; trans_started falls; FSM in IDLE.
- Bad grant: gnt_vld with ig_sel=3 and ig_req=4'b0001 → gnt_err pulse, no START. A gnt_vld during XFER → gnt_err pulse, burst unaffected.
- Address wrap: AW=8, addr=0xFC, len=1 → int_addr 0xFC then 0x00.
- Async reset mid-burst: assert rstN low during beat 2 of len=7. Expect all outputs 0 immediately and no ig_done; after release, a new grant starts cleanly at beat_cnt 0.

Source files
------------

// File: rtl/ig_pkg.sv
// Shared types for the ingress transfer controller: FSM encoding, port count
// and port index type.
package ig_pkg;

  localparam int NUM_PORTS = 4;

  typedef logic [1:0] port_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } ig_state_e;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_idx_t p);
    return 4'b0001 << p;
  endfunction

endpackage

// File: rtl/ig_port_mux.sv
// Pure 4:1 selector over the per-port descriptor and beat buses.
module ig_port_mux
  import ig_pkg::*;
#(
  parameter int AW   = 32,
  parameter int LENW = 4,
  parameter int DW   = 32
) (
  input  port_idx_t                  sel_i,
  input  logic [NUM_PORTS*AW-1:0]    addr_i,
  input  logic [NUM_PORTS*LENW-1:0]  len_i,
  input  logic [NUM_PORTS*DW-1:0]    data_i,
  input  logic [NUM_PORTS-1:0]       dvalid_i,
  output logic [AW-1:0]              addr_o,
  output logic [LENW-1:0]            len_o,
  output logic [DW-1:0]              data_o,
  output logic                       dvalid_o
);

  assign addr_o   = addr_i[int'(sel_i)*AW +: AW];
  assign len_o    = len_i[int'(sel_i)*LENW +: LENW];
  assign data_o   = data_i[int'(sel_i)*DW +: DW];
  assign dvalid_o = dvalid_i[sel_i];

endmodule

// File: rtl/ig_xfer_ctrl.sv
// Ingress transfer controller: latches the granted port's burst descriptor and
// streams that port's beats onto the internal bus with a stall watchdog.
module ig_xfer_ctrl
  import ig_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int LENW = 4,
  parameter int TMO  = 256
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic [NUM_PORTS-1:0]       ig_req,
  input  port_idx_t                  ig_sel,
  input  logic                       gnt_vld,
  input  logic [NUM_PORTS*AW-1:0]    ig_addr,
  input  logic [NUM_PORTS*LENW-1:0]  ig_len,
  input  logic [NUM_PORTS*DW-1:0]    ig_data,
  input  logic [NUM_PORTS-1:0]       ig_dvalid,
  output logic [NUM_PORTS-1:0]       ig_dack,
  output logic [NUM_PORTS-1:0]       ig_done,
  output logic                       int_valid,
  input  logic                       int_ready,
  output logic [AW-1:0]              int_addr,
  output logic [DW-1:0]              int_data,
  output logic                       int_first,
  output logic                       int_last,
  output logic                       trans_started,
  output logic                       xfer_err,
  output logic                       gnt_err
);

  localparam int              WDW    = (TMO > 1) ? $clog2(TMO) : 1;
  localparam bit              WD_EN  = (TMO > 0);
  localparam logic [WDW-1:0]  WD_LIM = WDW'((TMO > 0) ? (TMO - 1) : 0);
  localparam logic [AW-1:0]   ADDR_STEP = AW'(DW / 8);

  ig_state_e              state_q, state_d;
  port_idx_t              port_q, port_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [LENW-1:0]        len_q, len_d;
  logic [LENW-1:0]        cnt_q, cnt_d;
  logic [WDW-1:0]         wd_q, wd_d;
  logic [NUM_PORTS-1:0]   done_q, done_d;
  logic                   xfer_err_q, xfer_err_d;
  logic                   gnt_err_q, gnt_err_d;
  logic                   started_q, started_d;

  logic [AW-1:0]          sel_addr_s;
  logic [LENW-1:0]        sel_len_s;
  logic [DW-1:0]          sel_data_unused_s;
  logic                   sel_dvalid_unused_s;
  logic [AW-1:0]          beat_addr_unused_s;
  logic [LENW-1:0]        beat_len_unused_s;
  logic [DW-1:0]          beat_data_s;
  logic                   beat_dvalid_s;

  logic                   in_xfer_s;
  logic                   accept_s;
  logic                   last_s;

  // Descriptor path follows the arbiter's selection; beat path follows the latched port.
  ig_port_mux #(.AW(AW), .LENW(LENW), .DW(DW)) u_sel_mux (
    .sel_i    (ig_sel),
    .addr_i   (ig_addr),
    .len_i    (ig_len),
    .data_i   (ig_data),
    .dvalid_i (ig_dvalid),
    .addr_o   (sel_addr_s),
    .len_o    (sel_len_s),
    .data_o   (sel_data_unused_s),
    .dvalid_o (sel_dvalid_unused_s)
  );

  ig_port_mux #(.AW(AW), .LENW(LENW), .DW(DW)) u_beat_mux (
    .sel_i    (port_q),
    .addr_i   (ig_addr),
    .len_i    (ig_len),
    .data_i   (ig_data),
    .dvalid_i (ig_dvalid),
    .addr_o   (beat_addr_unused_s),
    .len_o    (beat_len_unused_s),
    .data_o   (beat_data_s),
    .dvalid_o (beat_dvalid_s)
  );

  assign in_xfer_s = (state_q == XFER);
  assign accept_s  = in_xfer_s & beat_dvalid_s & int_ready;
  assign last_s    = (cnt_q == len_q);

  // Next-state, descriptor, beat counter and watchdog logic.
  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    wd_d       = wd_q;
    done_d     = '0;
    xfer_err_d = 1'b0;
    gnt_err_d  = gnt_vld & ((state_q != IDLE) | ~ig_req[ig_sel]);

    case (state_q)
      IDLE: begin
        if (gnt_vld && ig_req[ig_sel]) begin
          port_d  = ig_sel;
          addr_d  = sel_addr_s;
          len_d   = sel_len_s;
          cnt_d   = '0;
          wd_d    = '0;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d = XFER;
      end
      XFER: begin
        // An accept in the expiry cycle takes priority over the abort.
        if (accept_s) begin
          addr_d = addr_q + ADDR_STEP;
          wd_d   = '0;
          if (last_s) begin
            state_d = DONE;
            done_d  = port_onehot(port_q);
          end else begin
            cnt_d = cnt_q + LENW'(1);
          end
        end else if (WD_EN && (wd_q == WD_LIM)) begin
          state_d    = DONE;
          xfer_err_d = 1'b1;
        end else if (WD_EN) begin
          wd_d = wd_q + WDW'(1);
        end else begin
          wd_d = wd_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    started_d = (state_d == START) || (state_d == XFER);
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      port_q     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      wd_q       <= '0;
      done_q     <= '0;
      xfer_err_q <= 1'b0;
      gnt_err_q  <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wd_q       <= wd_d;
      done_q     <= done_d;
      xfer_err_q <= xfer_err_d;
      gnt_err_q  <= gnt_err_d;
      started_q  <= started_d;
    end
  end

  // Beat-path outputs are forced to zero outside XFER so reset and idle look clean.
  assign int_valid     = in_xfer_s & beat_dvalid_s;
  assign int_data      = in_xfer_s ? beat_data_s : '0;
  assign int_addr      = in_xfer_s ? addr_q : '0;
  assign int_first     = in_xfer_s & (cnt_q == '0);
  assign int_last      = in_xfer_s & last_s;
  assign ig_dack       = accept_s ? port_onehot(port_q) : '0;
  assign ig_done       = done_q;
  assign xfer_err      = xfer_err_q;
  assign gnt_err       = gnt_err_q;
  assign trans_started = started_q;

endmodule

// File: tb/tb_ig_xfer_ctrl.sv
// Scoreboard bench for ig_xfer_ctrl: expected beats are queued when a burst is
// set up and compared as the internal bus accepts them.
module tb_ig_xfer_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int LENW = 4;
  localparam int TMO  = 8;

  logic               clk = 1'b0;
  logic               rstN;
  logic [3:0]         ig_req;
  logic [1:0]         ig_sel;
  logic               gnt_vld;
  logic [4*AW-1:0]    ig_addr;
  logic [4*LENW-1:0]  ig_len;
  logic [4*DW-1:0]    ig_data;
  logic [3:0]         ig_dvalid;
  logic [3:0]         ig_dack;
  logic [3:0]         ig_done;
  logic               int_valid;
  logic               int_ready;
  logic [AW-1:0]      int_addr;
  logic [DW-1:0]      int_data;
  logic               int_first;
  logic               int_last;
  logic               trans_started;
  logic               xfer_err;
  logic               gnt_err;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        first;
    logic        last;
    int          port;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    acc_cnt [4];
  int    acc_total = 0;
  int    cur_port = 0;
  int    cyc;
  int    a0;

  always #5 clk = ~clk;

  ig_xfer_ctrl #(.DW(DW), .AW(AW), .LENW(LENW), .TMO(TMO)) dut (
    .clk           (clk),
    .rstN          (rstN),
    .ig_req        (ig_req),
    .ig_sel        (ig_sel),
    .gnt_vld       (gnt_vld),
    .ig_addr       (ig_addr),
    .ig_len        (ig_len),
    .ig_data       (ig_data),
    .ig_dvalid     (ig_dvalid),
    .ig_dack       (ig_dack),
    .ig_done       (ig_done),
    .int_valid     (int_valid),
    .int_ready     (int_ready),
    .int_addr      (int_addr),
    .int_data      (int_data),
    .int_first     (int_first),
    .int_last      (int_last),
    .trans_started (trans_started),
    .xfer_err      (xfer_err),
    .gnt_err       (gnt_err)
  );

  function automatic logic [31:0] mkdata(input int p, input int idx);
    return 32'hA000_0000 + 32'(p << 24) + 32'(idx);
  endfunction

  // Each port's source advances its beat data only when a beat is accepted.
  always_comb begin
    ig_data = '0;
    for (int p = 0; p < 4; p++) ig_data[p*DW +: DW] = mkdata(p, acc_cnt[p]);
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic grant(input int p);
    gnt_vld = 1'b1;
    ig_sel  = 2'(p);
    step();
    gnt_vld = 1'b0;
  endtask

  task automatic set_desc(input int p, input logic [31:0] a, input int len);
    ig_addr[p*AW +: AW]     = a;
    ig_len[p*LENW +: LENW]  = LENW'(len);
  endtask

  task automatic push_burst(input int p, input logic [31:0] a, input int len);
    beat_t b;
    for (int k = 0; k <= len; k++) begin
      b.addr  = a + 32'(4 * k);
      b.data  = mkdata(p, acc_cnt[p] + k);
      b.first = (k == 0);
      b.last  = (k == len);
      b.port  = p;
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (ig_done == 4'b0000 && !xfer_err && n < 50);
    check_eq("done_seen", 64'(ig_done != 4'b0000 || xfer_err), 64'd1);
  endtask

  task automatic chk_zero(input string tag);
    check_eq({tag, "_ctl"}, 64'({int_valid, ig_dack, ig_done, trans_started,
                                 xfer_err, gnt_err, int_first, int_last}), 64'd0);
    check_eq({tag, "_addr"}, 64'(int_addr), 64'd0);
    check_eq({tag, "_data"}, 64'(int_data), 64'd0);
  endtask

  // Source-side acceptance tracking, sampled on the edge where the beat is taken.
  initial begin
    forever begin
      @(posedge clk);
      if (rstN && int_valid && int_ready) acc_cnt[cur_port]++;
    end
  end

  // Scoreboard monitor: compares accepted beats and holds stalled beats stable.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rstN) begin
        if (int_valid && int_ready) begin
          acc_total++;
          if (exp_q.size() == 0) begin
            check_eq("beat_unexpected", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            check_eq("beat_addr", 64'(int_addr), 64'(e.addr));
            check_eq("beat_data", 64'(int_data), 64'(e.data));
            check_eq("beat_first", 64'(int_first), 64'(e.first));
            check_eq("beat_last", 64'(int_last), 64'(e.last));
            check_eq("beat_dack", 64'(ig_dack), 64'(4'b0001 << e.port));
          end
        end else begin
          check_eq("idle_dack", 64'(ig_dack), 64'd0);
          if (int_valid && exp_q.size() > 0) begin
            check_eq("stall_addr", 64'(int_addr), 64'(exp_q[0].addr));
            check_eq("stall_data", 64'(int_data), 64'(exp_q[0].data));
          end
        end
      end
    end
  end

  initial begin
    rstN = 1'b0; ig_req = '0; ig_sel = '0; gnt_vld = 1'b0;
    ig_addr = '0; ig_len = '0; ig_dvalid = '0; int_ready = 1'b0;
    #1;
    chk_zero("reset");
    step(); step();
    rstN = 1'b1;
    step();

    // Normal burst on port 2; other ports' dvalid must be ignored.
    cur_port = 2; set_desc(2, 32'h100, 3);
    ig_req = 4'b0100; ig_dvalid = 4'b1111; int_ready = 1'b1;
    push_burst(2, 32'h100, 3);
    grant(2);
    check_eq("t1_started", 64'(trans_started), 64'd1);
    set_desc(2, 32'hDEAD, 0);
    wait_done(cyc);
    check_eq("t1_latency", 64'(cyc), 64'd5);
    check_eq("t1_done", 64'(ig_done), 64'(4'b0100));
    check_eq("t1_err", 64'(xfer_err), 64'd0);
    check_eq("t1_started_dn", 64'(trans_started), 64'd0);
    check_eq("t1_q_empty", 64'(exp_q.size()), 64'd0);
    step();
    check_eq("t1_done_pulse", 64'(ig_done), 64'd0);
    ig_req = 4'b0000;

    // Backpressure on port 0.
    cur_port = 0; set_desc(0, 32'h200, 1);
    ig_req = 4'b0001; ig_dvalid = 4'b0001;
    push_burst(0, 32'h200, 1);
    a0 = acc_total;
    grant(0);
    step(); int_ready = 1'b0;
    step(); int_ready = 1'b1;
    step(); int_ready = 1'b0;
    step(); int_ready = 1'b1;
    step();
    check_eq("t2_done", 64'(ig_done), 64'(4'b0001));
    check_eq("t2_err", 64'(xfer_err), 64'd0);
    check_eq("t2_accepts", 64'(acc_total - a0), 64'd2);
    step();
    ig_req = 4'b0000;

    // Watchdog abort on port 1 with no data offered.
    cur_port = 1; set_desc(1, 32'h300, 2);
    ig_req = 4'b0010; ig_dvalid = 4'b0000; int_ready = 1'b1;
    grant(1);
    wait_done(cyc);
    check_eq("t3_cycles", 64'(cyc), 64'd9);
    check_eq("t3_err", 64'(xfer_err), 64'd1);
    check_eq("t3_done", 64'(ig_done), 64'd0);
    check_eq("t3_started", 64'(trans_started), 64'd0);
    step();
    check_eq("t3_err_pulse", 64'(xfer_err), 64'd0);
    check_eq("t3_idle", 64'(trans_started), 64'd0);
    ig_req = 4'b0000;

    // Grant to a port that is not requesting.
    ig_req = 4'b0001;
    gnt_vld = 1'b1; ig_sel = 2'd3;
    step();
    gnt_vld = 1'b0;
    check_eq("t4_gnt_err", 64'(gnt_err), 64'd1);
    check_eq("t4_no_start", 64'(trans_started), 64'd0);
    step();
    check_eq("t4_gnt_err_pulse", 64'(gnt_err), 64'd0);
    check_eq("t4_still_idle", 64'(trans_started), 64'd0);

    // Grant during XFER is rejected; request drop mid-burst is ignored.
    cur_port = 0; set_desc(0, 32'h400, 2);
    ig_dvalid = 4'b0001; int_ready = 1'b1;
    push_burst(0, 32'h400, 2);
    grant(0);
    step();
    gnt_vld = 1'b1; ig_sel = 2'd0;
    step();
    gnt_vld = 1'b0; ig_req = 4'b0000;
    check_eq("t4_xfer_gnt_err", 64'(gnt_err), 64'd1);
    wait_done(cyc);
    check_eq("t4_latency", 64'(cyc), 64'd2);
    check_eq("t4_done", 64'(ig_done), 64'(4'b0001));
    step();

    // Address wraparound on port 3.
    cur_port = 3; set_desc(3, 32'hFFFF_FFFC, 1);
    ig_req = 4'b1000; ig_dvalid = 4'b1000;
    push_burst(3, 32'hFFFF_FFFC, 1);
    grant(3);
    wait_done(cyc);
    check_eq("t5_latency", 64'(cyc), 64'd3);
    check_eq("t5_done", 64'(ig_done), 64'(4'b1000));
    step();
    ig_req = 4'b0000;

    // Asynchronous reset during beat 2 of an 8-beat burst.
    cur_port = 1; set_desc(1, 32'h500, 7);
    ig_req = 4'b0010; ig_dvalid = 4'b0010;
    push_burst(1, 32'h500, 7);
    grant(1);
    step(); step(); step();
    check_eq("t6_beat2_addr", 64'(int_addr), 64'h508);
    rstN = 1'b0;
    #1;
    chk_zero("t6_rst");
    exp_q.delete();
    step();
    check_eq("t6_no_done", 64'(ig_done), 64'd0);
    step();
    rstN = 1'b1;
    step();
    check_eq("t6_idle", 64'(trans_started), 64'd0);

    // Fresh single-beat burst after reset: first and last together.
    set_desc(1, 32'h600, 0);
    push_burst(1, 32'h600, 0);
    grant(1);
    wait_done(cyc);
    check_eq("t6_latency", 64'(cyc), 64'd2);
    check_eq("t6_done", 64'(ig_done), 64'(4'b0010));
    check_eq("t6_q_empty", 64'(exp_q.size()), 64'd0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
